window_fetch_buffer: RTL and testbench
======================================

// Module: window_fetch_buffer
// PURPOSE
//  Downstream consumer of the address counter. Drives the counter's enable and
//  issues sync-memory reads at the counter's address.
//  Packs GROUP consecutive read words into one window; hands it out on valid/ready.
//  Repeats for a programmed number of windows. Feeds the PE/MAC stage.
// PARAMETERS
//  ADDR_WIDTH  8  width of addr_in / mem_addr
//  DATA_WIDTH  8  width of one memory word
//  GROUP       3  words per window (>=1); matches counter carry-out period
// PORTS
//  clk        in   1                    clock, rising edge
//  reset      in   1                    asynchronous, active-high
//  start      in   1                    pulse: begin job (ignored while busy)
//  num_groups in   8                    windows to fetch; sampled on accepted start
//  busy       out  1                    high from accepted start until done
//  done       out  1                    1-cycle pulse at job end
//  cnt_en     out  1                    enable to address counter
//  addr_in    in   ADDR_WIDTH           current counter address
//  mem_rd     out  1                    memory read strobe
//  mem_addr   out  ADDR_WIDTH           read address (= addr_in, combinational)
//  mem_rdata  in   DATA_WIDTH           read data, valid 1 cycle after mem_rd
//  out_valid  out  1                    window available
//  out_ready  in   1                    consumer accepts window
//  out_data   out  GROUP*DATA_WIDTH     window; word 0 (first read) in LSBs
// BEHAVIOUR
//  Reset: state IDLE. busy, done, cnt_en, mem_rd, out_valid = 0. out_data = 0.
//   Counters cleared. Reset mid-job aborts immediately with no done pulse.
//  FSM IDLE->FETCH->DRAIN->HOLD:
//   IDLE: start & num_groups!=0 -> FETCH, latch num_groups, busy=1.
//         start & num_groups==0 -> done pulse next cycle, stay IDLE, busy stays 0.
//   FETCH: cnt_en=mem_rd=1 for exactly GROUP consecutive cycles. rd_idx 0..GROUP-1.
//          After read GROUP-1 is issued -> DRAIN.
//   DRAIN: 1 cycle; the last word is captured. -> HOLD.
//   HOLD: out_valid=1. out_data is stable while out_valid & !out_ready.
//     On out_valid&out_ready: grp_cnt++. If grp_cnt==num_groups -> IDLE.
//     In that case done=1 in the next cycle and busy=0. Else -> FETCH.
//  Capture: mem_rdata of the read issued at cycle t is written to slot rd_idx(t) at t+1.
//  Latency: start at cycle 0 -> first out_valid at cycle GROUP+2.
//  Address sequence is owned by the counter. Block never resets it.
//   Wrap-around of addr_in is passed through unchanged.
//  start while busy: ignored. out_ready while !out_valid: ignored.
//  grp_cnt is 8 bits. num_groups=255 completes without overflow.
// CONFIGURATION
//  WFB_PREFETCH_EN defined:
//   - Adds a shadow buffer.
//   - In HOLD, if windows remain and the shadow is empty, the block fetches the next
//     window into the shadow (same GROUP-cycle FETCH timing, cnt_en/mem_rd asserted).
//   - On handshake with the shadow full: shadow copies to output, and out_valid stays 1
//     with no bubble.
//   - With out_ready tied 1, steady state is one window per GROUP cycles.
//  WFB_PREFETCH_EN undefined:
//   - Single buffer. No reads are issued during HOLD.
//   - Steady-state throughput: one window per GROUP+2 cycles plus handshake wait.
// STRUCTURE
//  wfb_pkg: state enum (IDLE, FETCH, DRAIN, HOLD) and MEM_LATENCY=1 constant.
//  Sub-module group_shift_buffer:
//   - GROUP x DATA_WIDTH register file with write index and parallel output.
//   - Instantiated once, or twice with WFB_PREFETCH_EN.
//  Top level holds the FSM, rd_idx, grp_cnt, and handshake logic.
// TESTING
//  Bench: 1-cycle-latency memory model with mem[a]=a+8'h10; AddressCounter upstream, OFFSET=0.
//  1. Reset, start, num_groups=1, ready=1:
//     out_valid at cycle 5, out_data={8'h12,8'h11,8'h10}, done one cycle after handshake.
//  2. num_groups=3, out_ready low for 4 cycles in each HOLD:
//     out_data stable while stalled; windows 10-12, 13-15, 16-18; exactly 9 cnt_en cycles.
//  3. start with num_groups=0 -> done pulse next cycle; no mem_rd, busy stays 0.
//  4. Assert reset during the 2nd FETCH -> all outputs 0 next edge; no done.
//     A new start then behaves as scenario 1 from the current counter address.
//  5. Pulse start while busy -> ignored; grp_cnt and window count unchanged.
//  6. WFB_PREFETCH_EN, num_groups=4, ready=1:
//     out_valid continuous after the first window; 12 mem_rd total.

Source files
------------

// File: rtl/wfb_pkg.sv
// ---------------------------------------------------------------------------
// wfb_pkg
// Shared definitions for the window fetch buffer.
//   wfb_state_e  : control FSM states (IDLE, FETCH, DRAIN, HOLD)
//   MEM_LATENCY  : read latency of the attached synchronous memory, in cycles
//   idx_width()  : width of an index into a GROUP-word window (at least 1 bit)
// ---------------------------------------------------------------------------
package wfb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } wfb_state_e;

   localparam int MEM_LATENCY = 1;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wfb_group_shift_buffer.sv
// ---------------------------------------------------------------------------
// group_shift_buffer
// GROUP x DATA_WIDTH register file. One word is written per cycle at an
// explicit index; the whole window is presented in parallel, word 0 in the
// LSBs. Cleared by reset.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   i_wr_en    in   write strobe
//   i_wr_idx   in   slot to write (0..GROUP-1)
//   i_wr_data  in   word to write
//   o_data     out  GROUP*DATA_WIDTH parallel window
// ---------------------------------------------------------------------------
module group_shift_buffer
   import wfb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int GROUP      = 3,
   localparam int IDX_W     = idx_width(GROUP)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_wr_en,
   input  logic [IDX_W-1:0]            i_wr_idx,
   input  logic [DATA_WIDTH-1:0]       i_wr_data,
   output logic [GROUP*DATA_WIDTH-1:0] o_data
);

   logic [DATA_WIDTH-1:0] r_word [GROUP];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < GROUP; i++) r_word[i] <= '0;
      end else begin
         for (int i = 0; i < GROUP; i++) begin
            if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_word[i] <= i_wr_data;
         end
      end
   end

   always_comb begin
      o_data = '0;
      for (int i = 0; i < GROUP; i++) o_data[i*DATA_WIDTH +: DATA_WIDTH] = r_word[i];
   end

endmodule

// File: rtl/window_fetch_buffer.sv
// ---------------------------------------------------------------------------
// window_fetch_buffer
// Drives the upstream address counter's enable and issues synchronous memory
// reads at the counter's address, packing GROUP consecutive words into one
// window that is handed out on a valid/ready interface. Repeats for a
// programmed number of windows per job.
//
// Build option: define WFB_PREFETCH_EN to add a second window buffer so the
// next window is fetched while the current one waits for the consumer.
// Without it a single buffer is used and no reads are issued during HOLD.
//
// Ports:
//   clk, reset   clock (rising edge); asynchronous active-high reset
//   start        pulse: begin a job (ignored while busy)
//   num_groups   windows per job, sampled on an accepted start
//   busy / done  job in progress / 1-cycle pulse at job end
//   cnt_en       advance the upstream address counter
//   addr_in      current counter address
//   mem_rd       memory read strobe; mem_addr = addr_in
//   mem_rdata    read data, valid MEM_LATENCY cycle after mem_rd
//   out_valid / out_ready / out_data   window handshake; word 0 in LSBs
// ---------------------------------------------------------------------------
module window_fetch_buffer
   import wfb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int GROUP      = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [7:0]                  num_groups,
   output logic                        busy,
   output logic                        done,
   output logic                        cnt_en,
   input  logic [ADDR_WIDTH-1:0]       addr_in,
   output logic                        mem_rd,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   input  logic [DATA_WIDTH-1:0]       mem_rdata,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [GROUP*DATA_WIDTH-1:0] out_data
);

   localparam int              IDX_W    = idx_width(GROUP);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP - 1);

   wfb_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_rd_idx;
   logic [7:0]       r_num_groups;
   logic [7:0]       r_grp_cnt;
   logic             r_done;
   // Read issued in cycle t returns in t+1; these carry the slot index along.
   logic             r_cap_vld;
   logic [IDX_W-1:0] r_cap_idx;

   logic w_fetch, w_last_rd, w_hs, w_last_grp, w_start_ok, w_start_zero;

   assign w_last_rd    = (r_rd_idx == LAST_IDX);
   assign w_hs         = out_valid & out_ready;
   assign w_last_grp   = ((r_grp_cnt + 8'd1) == r_num_groups);
   assign w_start_ok   = (r_state == IDLE) & start & (num_groups != 8'd0);
   assign w_start_zero = (r_state == IDLE) & start & (num_groups == 8'd0);

   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign cnt_en   = w_fetch;
   assign mem_rd   = w_fetch;
   assign mem_addr = addr_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_rd_idx     <= '0;
         r_num_groups <= '0;
         r_grp_cnt    <= '0;
         r_done       <= 1'b0;
         r_cap_vld    <= 1'b0;
         r_cap_idx    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_done    <= w_start_zero | (w_hs & w_last_grp);
         r_cap_vld <= w_fetch;
         r_cap_idx <= r_rd_idx;
         if (w_fetch) r_rd_idx <= w_last_rd ? '0 : r_rd_idx + IDX_W'(1);
         if (w_start_ok) begin
            r_num_groups <= num_groups;
            r_grp_cnt    <= 8'd0;
         end else if (w_hs) begin
            r_grp_cnt <= r_grp_cnt + 8'd1;
         end
      end
   end

`ifdef WFB_PREFETCH_EN
   // Two window buffers used ping-pong: r_wr_ptr selects the one being filled,
   // r_rd_ptr the one shown on out_data. Handing the read pointer over to a
   // full buffer is the shadow-to-output transfer, so out_valid stays high.
   logic                        r_wr_ptr, r_rd_ptr, r_cap_buf;
   logic [1:0]                  r_full;
   logic [7:0]                  r_issued;   // windows whose reads are all issued
   logic [GROUP*DATA_WIDTH-1:0] w_buf0, w_buf1;
   logic                        w_more, w_more_after, w_cap_last;

   assign w_more       = (r_issued < r_num_groups);
   assign w_more_after = (({1'b0, r_issued} + 9'd1) < {1'b0, r_num_groups});
   assign w_cap_last   = r_cap_vld & (r_cap_idx == LAST_IDX);
   assign out_valid    = r_full[r_rd_ptr];
   assign out_data     = r_rd_ptr ? w_buf1 : w_buf0;

   always_comb begin
      w_state_nxt = r_state;
      w_fetch     = 1'b0;
      case (r_state)
         IDLE:  if (w_start_ok) w_state_nxt = FETCH;
         FETCH: begin
            w_fetch = 1'b1;
            // Chain straight into the next burst when its buffer is free.
            if (w_last_rd && !(w_more_after && !r_full[~r_wr_ptr])) w_state_nxt = DRAIN;
         end
         DRAIN: w_state_nxt = HOLD;
         HOLD: begin
            if (w_hs && w_last_grp)             w_state_nxt = IDLE;
            else if (w_more && !r_full[r_wr_ptr]) w_state_nxt = FETCH;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_cap_buf <= 1'b0;
         r_full    <= 2'b00;
         r_issued  <= 8'd0;
      end else begin
         r_cap_buf <= r_wr_ptr;
         if (w_start_ok) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_full   <= 2'b00;
            r_issued <= 8'd0;
         end else begin
            if (w_fetch && w_last_rd) begin
               r_issued <= r_issued + 8'd1;
               r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_hs) r_rd_ptr <= ~r_rd_ptr;
            for (int b = 0; b < 2; b++) begin
               if (w_cap_last && (r_cap_buf == 1'(b)))  r_full[b] <= 1'b1;
               else if (w_hs && (r_rd_ptr == 1'(b)))    r_full[b] <= 1'b0;
            end
         end
      end
   end

   group_shift_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .GROUP      (GROUP)
   ) u_buf0 (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (r_cap_vld & ~r_cap_buf),
      .i_wr_idx  (r_cap_idx),
      .i_wr_data (mem_rdata),
      .o_data    (w_buf0)
   );

   group_shift_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .GROUP      (GROUP)
   ) u_buf1 (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (r_cap_vld & r_cap_buf),
      .i_wr_idx  (r_cap_idx),
      .i_wr_data (mem_rdata),
      .o_data    (w_buf1)
   );
`else
   assign out_valid = (r_state == HOLD);

   always_comb begin
      w_state_nxt = r_state;
      w_fetch     = 1'b0;
      case (r_state)
         IDLE:  if (w_start_ok) w_state_nxt = FETCH;
         FETCH: begin
            w_fetch = 1'b1;
            if (w_last_rd) w_state_nxt = DRAIN;
         end
         DRAIN: w_state_nxt = HOLD;
         HOLD:  if (w_hs) w_state_nxt = w_last_grp ? IDLE : FETCH;
         default: w_state_nxt = IDLE;
      endcase
   end

   group_shift_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .GROUP      (GROUP)
   ) u_buf0 (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (r_cap_vld),
      .i_wr_idx  (r_cap_idx),
      .i_wr_data (mem_rdata),
      .o_data    (out_data)
   );
`endif

endmodule

// File: tb/tb_window_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_window_fetch_buffer
// Directed bench for window_fetch_buffer with an upstream address counter
// (OFFSET 0) and a 1-cycle synchronous memory holding mem[a] = a + 8'h10.
// Honours WFB_PREFETCH_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_window_fetch_buffer;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int G  = 3;

   logic          clk, reset, start, busy, done, cnt_en, mem_rd;
   logic          out_valid, out_ready, cnt_clr;
   logic [7:0]    num_groups;
   logic [AW-1:0] addr_cnt, mem_addr;
   logic [DW-1:0] mem_rdata;
   logic [G*DW-1:0] out_data;

   int n_assert = 0;
   int n_fail   = 0;
   int n_cnt = 0, n_rd = 0, n_done = 0, n_hs = 0, n_rd_hold = 0;

   window_fetch_buffer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .GROUP      (G)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_groups (num_groups),
      .busy       (busy),
      .done       (done),
      .cnt_en     (cnt_en),
      .addr_in    (addr_cnt),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Upstream address counter: only the bench clears it, never the DUT.
   always @(posedge clk) begin
      if (cnt_clr)     addr_cnt <= '0;
      else if (cnt_en) addr_cnt <= addr_cnt + 8'd1;
   end

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem_addr + 8'h10;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Tally the current cycle's outputs, then advance to 1 time unit after the edge.
   task automatic step();
      if (cnt_en)                 n_cnt++;
      if (mem_rd)                 n_rd++;
      if (mem_rd && out_valid)    n_rd_hold++;
      if (done)                   n_done++;
      if (out_valid && out_ready) n_hs++;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         step();
         k++;
      end
      chk(tag, done, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      step();
   endtask

   function automatic logic [23:0] win(input logic [7:0] b);
      logic [7:0] w0, w1, w2;
      w0 = b + 8'h10;
      w1 = b + 8'h11;
      w2 = b + 8'h12;
      return {w2, w1, w0};
   endfunction

   initial begin
      int k, t0, t1, nw, last, s_cnt, s_rd, s_hs, s_done;
      logic [7:0]  base;
      logic [23:0] hold_data;

      // ---------------- reset ----------------
      reset = 1'b1; cnt_clr = 1'b1; start = 1'b0; num_groups = 8'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   busy,      1'b0);
      chk("rst_done",   done,      1'b0);
      chk("rst_cnt_en", cnt_en,    1'b0);
      chk("rst_mem_rd", mem_rd,    1'b0);
      chk("rst_valid",  out_valid, 1'b0);
      chk("rst_data",   out_data,  24'h0);
      reset = 1'b0; cnt_clr = 1'b0;
      step();

      // ---------------- 1: single window, ready high ----------------
      base = addr_cnt; s_cnt = n_cnt;
      start = 1'b1; num_groups = 8'd1; out_ready = 1'b1;
      chk("s1_busy_c0", busy, 1'b0);
      step(); start = 1'b0;                       // cycle 1
      chk("s1_rd_c1",   mem_rd,   1'b1);
      chk("s1_addr_c1", mem_addr, base);
      chk("s1_busy_c1", busy,     1'b1);
      step(); step(); step();                     // cycle 4
      chk("s1_valid_c4", out_valid, 1'b0);
      chk("s1_rd_c4",    mem_rd,    1'b0);
      step();                                     // cycle 5
      chk("s1_valid_c5", out_valid, 1'b1);
      chk("s1_data",     out_data,  win(base));
      step();                                     // cycle 6
      chk("s1_done",  done,      1'b1);
      chk("s1_busy",  busy,      1'b0);
      chk("s1_valid", out_valid, 1'b0);
      step();
      chk("s1_done_pulse", done, 1'b0);
      chk("s1_cnt_en", n_cnt - s_cnt, 3);

      // ---------------- 2: three windows, 4-cycle stall each ----------------
      clr_cnt();
      base = addr_cnt; s_cnt = n_cnt; s_hs = n_hs; s_rd = n_rd; k = n_rd_hold;
      start = 1'b1; num_groups = 8'd3; out_ready = 1'b0;
      step(); start = 1'b0;
      for (int w = 0; w < 3; w++) begin
         t0 = 0;
         while (!out_valid && t0 < 30) begin
            step();
            t0++;
         end
         hold_data = win(base + 8'(3 * w));
         chk("s2_valid", out_valid, 1'b1);
         chk("s2_data",  out_data,  hold_data);
         repeat (4) step();
         chk("s2_stall_valid", out_valid, 1'b1);
         chk("s2_stall_data",  out_data,  hold_data);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      wait_done("s2_done", 30);
      chk("s2_cnt_en", n_cnt - s_cnt, 9);
      chk("s2_mem_rd", n_rd - s_rd,   9);
      chk("s2_hs",     n_hs - s_hs,   3);
`ifndef WFB_PREFETCH_EN
      chk("s2_no_hold_rd", n_rd_hold - k, 0);
`endif

      // ---------------- 3: num_groups = 0 ----------------
      s_rd = n_rd;
      start = 1'b1; num_groups = 8'd0;
      chk("s3_busy_c0", busy, 1'b0);
      step(); start = 1'b0;
      chk("s3_done", done, 1'b1);
      chk("s3_busy", busy, 1'b0);
      step();
      chk("s3_done_pulse", done, 1'b0);
      chk("s3_no_rd", n_rd - s_rd, 0);

      // ---------------- 4: reset during the second fetch ----------------
      clr_cnt();
      s_done = n_done;
      start = 1'b1; num_groups = 8'd3; out_ready = 1'b1;
      step(); start = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
         step();
         k++;
      end
      step();                                     // first window taken
      chk("s4_fetching", mem_rd, 1'b1);
      reset = 1'b1;
      step();
      chk("s4_rst_busy",   busy,      1'b0);
      chk("s4_rst_cnt_en", cnt_en,    1'b0);
      chk("s4_rst_mem_rd", mem_rd,    1'b0);
      chk("s4_rst_valid",  out_valid, 1'b0);
      chk("s4_rst_data",   out_data,  24'h0);
      reset = 1'b0;
      step();
      chk("s4_no_done", n_done - s_done, 0);
`ifdef WFB_PREFETCH_EN
      chk("s4_addr_kept", addr_cnt, 8'd5);
`else
      chk("s4_addr_kept", addr_cnt, 8'd3);
`endif
      base = addr_cnt;
      start = 1'b1; num_groups = 8'd1; out_ready = 1'b1;
      step(); start = 1'b0;
      chk("s4_addr_c1", mem_addr, base);
      step(); step(); step();
      chk("s4_valid_c4", out_valid, 1'b0);
      step();
      chk("s4_valid_c5", out_valid, 1'b1);
      chk("s4_data",     out_data,  win(base));
      step();
      chk("s4_done", done, 1'b1);
      step();

      // ---------------- 5: start while busy ----------------
      clr_cnt();
      s_hs = n_hs; s_rd = n_rd;
      start = 1'b1; num_groups = 8'd2; out_ready = 1'b1;
      step(); start = 1'b0;
      step();
      start = 1'b1; num_groups = 8'd5;
      chk("s5_busy_at_pulse", busy, 1'b1);
      step(); start = 1'b0;
      t0 = -1; t1 = -1; k = 0;
      while (!done && k < 40) begin
         if (out_valid && out_ready) begin
            if (t0 < 0) t0 = k;
            else        t1 = k;
         end
         step();
         k++;
      end
      chk("s5_done",   done,        1'b1);
      chk("s5_hs",     n_hs - s_hs, 2);
      chk("s5_mem_rd", n_rd - s_rd, 6);
`ifdef WFB_PREFETCH_EN
      chk("s5_gap", t1 - t0, G);
`else
      chk("s5_gap", t1 - t0, G + 2);
`endif
      step();

      // ---------------- 7: num_groups = 255 ----------------
      clr_cnt();
      s_hs = n_hs; nw = 0; hold_data = 24'h0;
      start = 1'b1; num_groups = 8'd255; out_ready = 1'b1;
      step(); start = 1'b0;
      k = 0;
      while (!done && k < 2000) begin
         if (out_valid && out_ready) begin
            if (nw == 254) hold_data = out_data;
            nw++;
         end
         step();
         k++;
      end
      chk("s7_done", done, 1'b1);
      chk("s7_hs",   n_hs - s_hs, 255);
      chk("s7_last_window_wrap", hold_data, win(8'hFA));
      step();

`ifdef WFB_PREFETCH_EN
      // ---------------- 6: prefetch, ready high ----------------
      clr_cnt();
      s_rd = n_rd; nw = 0; last = 0; k = 0;
      start = 1'b1; num_groups = 8'd4; out_ready = 1'b1;
      step(); start = 1'b0;
      while (nw < 4 && k < 60) begin
         if (out_valid) begin
            chk("s6_data", out_data, win(8'(3 * nw)));
            if (nw > 0) chk("s6_gap", k - last, G);
            last = k;
            nw++;
         end
         step();
         k++;
      end
      chk("s6_windows", nw, 4);
      wait_done("s6_done", 10);
      chk("s6_mem_rd", n_rd - s_rd, 12);

      // shadow full, then back-to-back hand-off with no bubble
      clr_cnt();
      start = 1'b1; num_groups = 8'd2; out_ready = 1'b0;
      step(); start = 1'b0;
      repeat (12) step();
      chk("s6b_valid0", out_valid, 1'b1);
      chk("s6b_data0",  out_data,  win(8'h00));
      out_ready = 1'b1;
      step();
      chk("s6b_valid1", out_valid, 1'b1);
      chk("s6b_data1",  out_data,  win(8'h03));
      step();
      chk("s6b_done", done, 1'b1);
      out_ready = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
